hs_sync_rx_multi: RTL and testbench
===================================

HS_SYNC_RX_MULTI -- requirements
Module: hs_sync_rx_multi

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NCH, 4: channel count, legal 2..16.
- SYNC_STAGES, 2: synchronizer flop depth per channel, legal 2..4.
- PHASE4, 1: 1 = 4-phase level req/ack; 0 = 2-phase toggle req/ack.
- CHW, derived: max(1, clog2(NCH)).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1: single clock; every flop in the block is clocked on its rising edge.
- rst_n, in, 1: reset, synchronous, active-low.
- req_async, in, NCH: per-channel request levels from foreign domains, asynchronous to clk.
- ack, out, NCH: per-channel registered acknowledge back to the senders.
- busy, out, NCH: per-channel flag, high while the channel state is not IDLE.
- evt_valid, out, 1: registered flag, an event is presented.
- evt_ch, out, CHW: channel index of the presented event.
- evt_ready, in, 1: consumer accepts the presented event.
- ovf, out, NCH: sticky per-channel protocol-error flags.
- ovf_clr, in, NCH: per-channel single-cycle clear of ovf.

Function
REQ-003 Each req_async bit SHALL pass through SYNC_STAGES flops to give req_s; req_d SHALL be req_s delayed by one cycle.
REQ-004 Event detection SHALL be req_s & ~req_d when PHASE4=1, and req_s ^ req_d when PHASE4=0.
REQ-005 Each channel SHALL implement the FSM IDLE, PEND, ACKD. ACKD is used only when PHASE4=1.
REQ-006 IDLE -> PEND SHALL occur on the edge following a detected event.
REQ-007 PEND SHALL persist until the channel is accepted (evt_valid & evt_ready with evt_ch = channel).
- PHASE4=1: on that edge ack[i] <= 1 and state -> ACKD.
- PHASE4=0: on that edge ack[i] toggles and state -> IDLE.
REQ-008 In ACKD, when req_s[i]=0, the same edge SHALL set ack[i] <= 0 and state -> IDLE.
REQ-009 ovf[i] SHALL be set under either condition:
- PHASE4=0: an event is detected while channel i is in PEND.
- PHASE4=1: req_s[i] falls while channel i is in PEND.
The channel SHALL remain in PEND and deliver exactly one event.
REQ-010 ovf[i] SHALL clear on ovf_clr[i]; set SHALL win over a clear in the same cycle.
REQ-011 Presentation: when evt_valid=0, or when evt_valid & evt_ready, the next evt_valid/evt_ch SHALL be loaded from the PEND channels.
- The channel accepted in this cycle SHALL be excluded from selection.
- Selection SHALL be round-robin, searching upward from last-granted+1 and wrapping at NCH-1 -> 0.
REQ-012 While evt_valid=1 and evt_ready=0, evt_valid and evt_ch SHALL hold stable.
REQ-013 Throughput SHALL be one accepted event per cycle when evt_ready is held high and several channels are pending.
REQ-014 Latency: with req_async rising before edge k, evt_valid SHALL be high after edge k+SYNC_STAGES+2, provided no other event is presented.
REQ-015 The last-granted pointer SHALL update only on acceptance.
REQ-016 busy[i] SHALL be high in PEND and ACKD. The pending-request vector SHALL never drop a request.

Reset
REQ-017 While rst_n=0 at a clk edge, the block SHALL clear all of the following: synchronizer flops, req_d, ack, ovf, evt_valid, evt_ch, all states (IDLE). The last-granted pointer SHALL be set to NCH-1 so that channel 0 wins first.
REQ-018 Reset mid-handshake SHALL abandon the handshake: ack drops to 0, and no stale event is presented.
REQ-019 If req_async is already high when reset releases with PHASE4=1, the resulting 0->1 on req_s SHALL be treated as a new event.

Verification
REQ-020 NCH=4, SYNC_STAGES=2, PHASE4=1, evt_ready=1:
- Stimulus: raise req_async[2] before edge 10.
- Response: evt_valid=1, evt_ch=2 after edge 14; ack[2]=1 after edge 15.
- Then drop req_async[2]: ack[2]=0 four edges later; busy[2]=0.
REQ-021 Raise req_async[0], [1] and [3] together with evt_ready=1:
- Response: events ch0, ch1, ch3 on consecutive cycles.
- Then re-raise ch0 and ch1 after completion with the pointer at 3: order ch0, ch1.
REQ-022 Hold evt_ready=0 with two channels pending:
- Response: evt_ch holds a constant value for 20 cycles.
- Raise evt_ready for 2 cycles: both channels are accepted, with no duplicate.
REQ-023 PHASE4=0: toggle req_async[1] twice, 3 cycles apart, with evt_ready=0:
- Response: ovf[1]=1, exactly one event delivered, ack[1] toggled once.
- Pulse ovf_clr[1] on the same cycle as a new overflow: ovf[1] stays 1.
REQ-024 Assert rst_n=0 for 1 cycle while channel 2 is in ACKD with req_async[2] held high:
- Response: ack=0, evt_valid=0.
- After release: a new event on ch2 is presented after SYNC_STAGES+2 edges.

Source files
------------

// File: rtl/hs_sync_rx_multi.sv
// hs_sync_rx_multi: multi-channel req/ack receiver. Each channel synchronizes a foreign
// request, tracks its handshake in a small FSM, and a round-robin presenter hands one
// pending channel at a time to the consumer.
module hs_sync_rx_multi #(
    parameter int unsigned NCH         = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          PHASE4      = 1'b1,
    parameter int unsigned CHW         = ($clog2(NCH) > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] req_async,
    output logic [NCH-1:0] ack,
    output logic [NCH-1:0] busy,
    output logic           evt_valid,
    output logic [CHW-1:0] evt_ch,
    input  logic           evt_ready,
    output logic [NCH-1:0] ovf,
    input  logic [NCH-1:0] ovf_clr
);

    typedef enum logic [1:0] {StIdle, StPend, StAckd} chState_e;

    logic [NCH-1:0] syncQ [SYNC_STAGES];
    logic [NCH-1:0] reqS, reqD;
    logic [NCH-1:0] edgeDet, fallDet;
    logic [NCH-1:0] evtQ, fallQ;
    chState_e       stateQ [NCH];
    chState_e       stateD [NCH];
    logic [NCH-1:0] ackD, ovfD;
    logic [NCH-1:0] acceptVec, pendVec;
    logic           accepted;
    logic [CHW-1:0] lastGrantQ, lastGrantD;
    logic [CHW-1:0] startIdx, selCand, selIdx;
    logic           selFound;
    logic           evtValidD;
    logic [CHW-1:0] evtChD;

    assign reqS     = syncQ[SYNC_STAGES-1];
    assign edgeDet  = PHASE4 ? (reqS & ~reqD) : (reqS ^ reqD);
    assign fallDet  = reqD & ~reqS;
    assign accepted = evt_valid & evt_ready;

    // Synchronizer chain plus registered edge/fall detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                syncQ[s] <= '0;
            end
            reqD  <= '0;
            evtQ  <= '0;
            fallQ <= '0;
        end else begin
            syncQ[0] <= req_async;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                syncQ[s] <= syncQ[s-1];
            end
            reqD  <= reqS;
            evtQ  <= edgeDet;
            fallQ <= fallDet;
        end
    end

    // Decode which channel (if any) is accepted this cycle; derive busy and pending.
    always_comb begin
        acceptVec = '0;
        pendVec   = '0;
        busy      = '0;
        for (int i = 0; i < NCH; i++) begin
            acceptVec[i] = accepted && (evt_ch == CHW'(i));
            // The accepted channel must not be re-selected on the same edge.
            pendVec[i]   = (stateQ[i] == StPend) && !acceptVec[i];
            busy[i]      = (stateQ[i] != StIdle);
        end
    end

    // Per-channel handshake FSM next state, ack and sticky overflow.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            stateD[i] = stateQ[i];
            ackD[i]   = ack[i];
            ovfD[i]   = ovf[i] & ~ovf_clr[i];
            case (stateQ[i])
                StIdle: begin
                    if (evtQ[i]) begin
                        stateD[i] = StPend;
                    end
                end
                StPend: begin
                    // Protocol violation while waiting; the single pending event is kept.
                    if (PHASE4 ? fallQ[i] : evtQ[i]) begin
                        ovfD[i] = 1'b1;
                    end
                    if (acceptVec[i]) begin
                        if (PHASE4) begin
                            ackD[i]   = 1'b1;
                            stateD[i] = StAckd;
                        end else begin
                            ackD[i]   = ~ack[i];
                            stateD[i] = StIdle;
                        end
                    end
                end
                StAckd: begin
                    if (!reqS[i]) begin
                        ackD[i]   = 1'b0;
                        stateD[i] = StIdle;
                    end
                end
                default: stateD[i] = StIdle;
            endcase
        end
    end

    // Round-robin selection of the next event, searching upward from the last grant.
    always_comb begin
        startIdx = accepted ? evt_ch : lastGrantQ;
        selFound = 1'b0;
        selIdx   = '0;
        selCand  = '0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            selCand = CHW'((32'(startIdx) + k) % NCH);
            if (!selFound && pendVec[selCand]) begin
                selFound = 1'b1;
                selIdx   = selCand;
            end
        end
        evtValidD  = evt_valid;
        evtChD     = evt_ch;
        if (!evt_valid || accepted) begin
            evtValidD = selFound;
            evtChD    = selFound ? selIdx : evt_ch;
        end
        lastGrantD = accepted ? evt_ch : lastGrantQ;
    end

    // State, ack, overflow and presentation registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                stateQ[i] <= StIdle;
            end
            ack        <= '0;
            ovf        <= '0;
            evt_valid  <= 1'b0;
            evt_ch     <= '0;
            // Channel 0 wins the first arbitration after reset.
            lastGrantQ <= CHW'(NCH - 1);
        end else begin
            for (int i = 0; i < NCH; i++) begin
                stateQ[i] <= stateD[i];
            end
            ack        <= ackD;
            ovf        <= ovfD;
            evt_valid  <= evtValidD;
            evt_ch     <= evtChD;
            lastGrantQ <= lastGrantD;
        end
    end

endmodule

// File: tb/tb_hs_sync_rx_multi.sv
// Self-checking bench for hs_sync_rx_multi: one 4-phase and one 2-phase instance.
module tb_hs_sync_rx_multi;

    localparam int unsigned NCH = 4;
    localparam int unsigned CHW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [NCH-1:0] reqA, ackA, busyA, ovfA, clrA;
    logic           vA, rdyA;
    logic [CHW-1:0] chA;
    logic [NCH-1:0] reqB, ackB, busyB, ovfB, clrB;
    logic           vB, rdyB;
    logic [CHW-1:0] chB;

    int checks = 0;
    int errors = 0;

    // Scenario state.
    int             seq1 [3] = '{0, 1, 3};
    int             seq2 [2] = '{0, 1};
    logic [CHW-1:0] c0, c1, ch;
    int             got [$];
    int             nEvt;
    int             outA [NCH];
    int             outB [NCH];
    bit             stallA, stallB, drain;
    logic [CHW-1:0] heldA, heldB;

    hs_sync_rx_multi #(.NCH(NCH), .SYNC_STAGES(2), .PHASE4(1'b1)) dutA (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_async (reqA),
        .ack       (ackA),
        .busy      (busyA),
        .evt_valid (vA),
        .evt_ch    (chA),
        .evt_ready (rdyA),
        .ovf       (ovfA),
        .ovf_clr   (clrA)
    );

    hs_sync_rx_multi #(.NCH(NCH), .SYNC_STAGES(2), .PHASE4(1'b0)) dutB (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_async (reqB),
        .ack       (ackB),
        .busy      (busyB),
        .evt_valid (vB),
        .evt_ch    (chB),
        .evt_ready (rdyB),
        .ovf       (ovfB),
        .ovf_clr   (clrB)
    );

    task automatic checkVal(input string tag, input int unsigned got_v, input int unsigned exp_v);
        checks++;
        if (got_v != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got_v, exp_v);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic waitValidA(input string tag);
        int n = 0;
        while (!vA && n < 40) begin
            tick();
            n++;
        end
        checkVal(tag, vA, 1);
    endtask

    // Single 4-phase handshake on an otherwise idle DUT A with evt_ready held high.
    task automatic latencyA(input logic [CHW-1:0] c);
        rdyA    = 1'b1;
        reqA[c] = 1'b1;
        tick(4);
        checkVal("lat_early", vA, 0);
        tick(1);
        checkVal("lat_valid", vA, 1);
        checkVal("lat_ch", chA, c);
        tick(1);
        checkVal("lat_ack", ackA[c], 1);
        checkVal("lat_busy", busyA[c], 1);
        reqA[c] = 1'b0;
        tick(4);
        checkVal("rel_ack", ackA[c], 0);
        checkVal("rel_busy", busyA[c], 0);
    endtask

    initial begin
        rst_n = 1'b0;
        reqA = '0; rdyA = 1'b0; clrA = '0;
        reqB = '0; rdyB = 1'b0; clrB = '0;

        // Reset state.
        tick(3);
        checkVal("rst_ackA", ackA, 0);
        checkVal("rst_vA", vA, 0);
        checkVal("rst_busyA", busyA, 0);
        checkVal("rst_ovfA", ovfA, 0);
        checkVal("rst_vB", vB, 0);
        checkVal("rst_ackB", ackB, 0);
        rst_n = 1'b1;
        tick(2);

        // Latency and release, channel 2 then random channels.
        latencyA(2'd2);
        for (int r = 0; r < 3; r++) begin
            ch = CHW'($urandom_range(0, NCH - 1));
            latencyA(ch);
        end

        // Round-robin order from a fresh pointer.
        doReset();
        rdyA = 1'b1;
        reqA = 4'b1011;
        waitValidA("rr_valid");
        for (int i = 0; i < 3; i++) begin
            checkVal("rr_v", vA, 1);
            checkVal("rr_ch", chA, seq1[i]);
            tick();
        end
        checkVal("rr_done", vA, 0);
        reqA = '0;
        tick(6);
        checkVal("rr_ack_low", ackA, 0);
        reqA = 4'b0011;
        waitValidA("rr2_valid");
        for (int i = 0; i < 2; i++) begin
            checkVal("rr2_v", vA, 1);
            checkVal("rr2_ch", chA, seq2[i]);
            tick();
        end
        checkVal("rr2_done", vA, 0);
        reqA = '0;
        tick(6);

        // Stall with two pending channels, then accept both.
        doReset();
        rdyA = 1'b0;
        c0 = CHW'($urandom_range(0, 2));
        c1 = CHW'($urandom_range(int'(c0) + 1, 3));
        reqA[c0] = 1'b1;
        reqA[c1] = 1'b1;
        waitValidA("stall_valid");
        checkVal("stall_first", chA, c0);
        for (int i = 0; i < 20; i++) begin
            tick();
            checkVal("stall_hold_v", vA, 1);
            checkVal("stall_hold_ch", chA, c0);
        end
        rdyA = 1'b1;
        got.delete();
        for (int i = 0; i < 2; i++) begin
            if (vA) got.push_back(int'(chA));
            tick();
        end
        rdyA = 1'b0;
        checkVal("stall_n", got.size(), 2);
        if (got.size() == 2) begin
            checkVal("stall_acc0", got[0], c0);
            checkVal("stall_acc1", got[1], c1);
        end
        checkVal("stall_empty", vA, 0);
        reqA = '0;
        tick(6);

        // Reset while channel 2 sits in the acknowledged state with its request high.
        doReset();
        rdyA = 1'b1;
        reqA = 4'b0100;
        begin
            int n = 0;
            while (!ackA[2] && n < 40) begin
                tick();
                n++;
            end
        end
        checkVal("mid_ack_up", ackA[2], 1);
        rst_n = 1'b0;
        tick(1);
        checkVal("mid_rst_ack", ackA, 0);
        checkVal("mid_rst_v", vA, 0);
        checkVal("mid_rst_busy", busyA, 0);
        rst_n = 1'b1;
        tick(4);
        checkVal("mid_early", vA, 0);
        tick(1);
        checkVal("mid_valid", vA, 1);
        checkVal("mid_ch", chA, 2);
        reqA = '0;
        tick(6);

        // 2-phase overflow: two toggles while the first event is still pending.
        doReset();
        rdyB = 1'b0;
        reqB[1] = ~reqB[1];
        tick(3);
        reqB[1] = ~reqB[1];
        tick(8);
        checkVal("p2_ovf", ovfB[1], 1);
        checkVal("p2_v", vB, 1);
        checkVal("p2_ch", chB, 1);
        rdyB = 1'b1;
        nEvt = 0;
        for (int i = 0; i < 10; i++) begin
            if (vB && rdyB) nEvt++;
            tick();
        end
        rdyB = 1'b0;
        checkVal("p2_events", nEvt, 1);
        checkVal("p2_ack", ackB[1], 1);
        checkVal("p2_busy", busyB[1], 0);
        clrB[1] = 1'b1;
        tick();
        clrB[1] = 1'b0;
        checkVal("p2_clr", ovfB[1], 0);
        // Clear lands on the same edge as a fresh overflow: the set must win.
        reqB[1] = ~reqB[1];
        tick(3);
        reqB[1] = ~reqB[1];
        tick(3);
        checkVal("p2_ovf_pre", ovfB[1], 0);
        clrB[1] = 1'b1;
        tick();
        clrB[1] = 1'b0;
        checkVal("p2_set_wins", ovfB[1], 1);
        rdyB = 1'b1;
        tick(3);
        rdyB = 1'b0;
        checkVal("p2_drained", vB, 0);

        // Randomized traffic on both instances against per-channel request counters.
        reqA = '0;
        reqB = '0;
        doReset();
        tick(4);
        for (int i = 0; i < NCH; i++) begin
            outA[i] = 0;
            outB[i] = 0;
        end
        stallA = 1'b0;
        stallB = 1'b0;
        heldA  = '0;
        heldB  = '0;
        for (int cyc = 0; cyc < 1600; cyc++) begin
            drain = (cyc >= 1400);
            rdyA  = drain ? 1'b1 : ($urandom_range(0, 9) < 7);
            rdyB  = drain ? 1'b1 : ($urandom_range(0, 9) < 7);
            if (stallA) begin
                checkVal("rnd_a_hold_v", vA, 1);
                checkVal("rnd_a_hold_ch", chA, heldA);
            end
            if (stallB) begin
                checkVal("rnd_b_hold_v", vB, 1);
                checkVal("rnd_b_hold_ch", chB, heldB);
            end
            if (vA && rdyA) begin
                checkVal("rnd_a_src", outA[chA] > 0, 1);
                if (outA[chA] > 0) outA[chA]--;
            end
            if (vB && rdyB) begin
                checkVal("rnd_b_src", outB[chB] > 0, 1);
                if (outB[chB] > 0) outB[chB]--;
            end
            stallA = vA && !rdyA;
            heldA  = chA;
            stallB = vB && !rdyB;
            heldB  = chB;
            for (int i = 0; i < NCH; i++) begin
                if (!reqA[CHW'(i)] && !ackA[CHW'(i)] && !drain && $urandom_range(0, 3) == 0) begin
                    reqA[CHW'(i)] = 1'b1;
                    outA[i]++;
                end else if (reqA[CHW'(i)] && ackA[CHW'(i)] && $urandom_range(0, 1) == 0) begin
                    reqA[CHW'(i)] = 1'b0;
                end
                if (reqB[CHW'(i)] == ackB[CHW'(i)] && !drain && $urandom_range(0, 3) == 0) begin
                    reqB[CHW'(i)] = ~reqB[CHW'(i)];
                    outB[i]++;
                end
            end
            tick();
        end
        for (int i = 0; i < NCH; i++) begin
            checkVal("rnd_a_left", outA[i], 0);
            checkVal("rnd_b_left", outB[i], 0);
        end
        checkVal("rnd_a_ovf", ovfA, 0);
        checkVal("rnd_b_ovf", ovfB, 0);
        checkVal("rnd_a_busy", busyA, 0);
        checkVal("rnd_b_busy", busyB, 0);
        checkVal("rnd_b_ack", ackB, reqB);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
